pipelined_barrel_shifter: RTL and testbench

- Parametrised, pipelined logarithmic barrel shifter for the execute stage.
- Supports logical left/right, arithmetic right and rotate left/right on a WIDTH-bit operand.
- One pipeline register per log2 shift stage, with a valid/ready handshake on input and output.
- Replaces fixed 16-bit single-mode combinational shifters where timing or operand width demands it.

---
 rtl/pipelined_barrel_shifter.sv | 156 +++++++++++++++
 tb/tb_pipelined_barrel_shifter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined logarithmic barrel shifter: SLL/SRL/SRA/ROL/ROR with one register per shift stage.
// Define SHIFTER_FLAGS_EN to add the Zero and Carry result flags.
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 16,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] In,
  input  logic [CNT_W-1:0] Cnt,
  input  logic [2:0]       Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out
`ifdef SHIFTER_FLAGS_EN
  ,
  output logic             Zero,
  output logic             Carry
`endif
);

  localparam logic [2:0] OpSll = 3'b000;
  localparam logic [2:0] OpSrl = 3'b001;
  localparam logic [2:0] OpSra = 3'b010;
  localparam logic [2:0] OpRol = 3'b011;
  localparam logic [2:0] OpRor = 3'b100;

  // Shift by a fixed amount; sgn is the original operand MSB used as the SRA fill.
  function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] d,
                                                   input logic [2:0]       op,
                                                   input logic             sgn,
                                                   input int unsigned      amt);
    logic [WIDTH-1:0] fill;
    fill = sgn ? ~({WIDTH{1'b1}} >> amt) : '0;
    case (op)
      OpSll:   shift_stage = d << amt;
      OpSrl:   shift_stage = d >> amt;
      OpSra:   shift_stage = (d >> amt) | fill;
      OpRol:   shift_stage = (d << amt) | (d >> (WIDTH - amt));
      OpRor:   shift_stage = (d >> amt) | (d << (WIDTH - amt));
      default: shift_stage = d;
    endcase
  endfunction

  logic             r_valid [CNT_W];
  logic [WIDTH-1:0] r_data  [CNT_W];
  logic [2:0]       r_op    [CNT_W];
  logic [CNT_W-1:0] r_cnt   [CNT_W];
  logic             r_sign  [CNT_W];

  logic             w_v_in   [CNT_W];
  logic [WIDTH-1:0] w_d_in   [CNT_W];
  logic [2:0]       w_op_in  [CNT_W];
  logic [CNT_W-1:0] w_cnt_in [CNT_W];
  logic             w_sgn_in [CNT_W];
  logic [WIDTH-1:0] w_d_nxt  [CNT_W];

  logic w_advance;
  logic w_unused;

  assign w_advance = ~out_valid | out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_valid[CNT_W-1];
  assign Out       = r_data[CNT_W-1];

`ifdef SHIFTER_FLAGS_EN
  logic             r_carry [CNT_W];
  logic             w_c_in  [CNT_W];
  logic [CNT_W-1:0] w_carry_idx;
  logic             w_carry_acc;

  // Carry is the last bit to leave the operand, resolved once at accept.
  always_comb begin
    w_carry_idx = '0;
    w_carry_acc = 1'b0;
    if (Cnt != '0) begin
      case (Op)
        OpSll, OpRol: begin
          w_carry_idx = ~Cnt + CNT_W'(1);
          w_carry_acc = In[w_carry_idx];
        end
        OpSrl, OpSra, OpRor: begin
          w_carry_idx = Cnt - CNT_W'(1);
          w_carry_acc = In[w_carry_idx];
        end
        default: w_carry_acc = 1'b0;
      endcase
    end
  end

  assign Carry = r_carry[CNT_W-1];
  assign Zero  = out_valid & (Out == '0);
`endif

  for (genvar k = 0; k < CNT_W; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign w_v_in[k]   = in_valid;
      assign w_d_in[k]   = In;
      assign w_op_in[k]  = Op;
      assign w_cnt_in[k] = Cnt;
      assign w_sgn_in[k] = In[WIDTH-1];
`ifdef SHIFTER_FLAGS_EN
      assign w_c_in[k]   = w_carry_acc;
`endif
    end else begin : g_next
      assign w_v_in[k]   = r_valid[k-1];
      assign w_d_in[k]   = r_data[k-1];
      assign w_op_in[k]  = r_op[k-1];
      assign w_cnt_in[k] = r_cnt[k-1];
      assign w_sgn_in[k] = r_sign[k-1];
`ifdef SHIFTER_FLAGS_EN
      assign w_c_in[k]   = r_carry[k-1];
`endif
    end
    assign w_d_nxt[k] = w_cnt_in[k][k] ?
                        shift_stage(w_d_in[k], w_op_in[k], w_sgn_in[k], 1 << k) : w_d_in[k];
  end

  // Global stall: every stage holds, bubbles included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CNT_W; k++) begin
        r_valid[k] <= 1'b0;
        r_data[k]  <= '0;
        r_op[k]    <= '0;
        r_cnt[k]   <= '0;
        r_sign[k]  <= 1'b0;
`ifdef SHIFTER_FLAGS_EN
        r_carry[k] <= 1'b0;
`endif
      end
    end else if (w_advance) begin
      for (int k = 0; k < CNT_W; k++) begin
        r_valid[k] <= w_v_in[k];
        r_data[k]  <= w_d_nxt[k];
        r_op[k]    <= w_op_in[k];
        r_cnt[k]   <= w_cnt_in[k];
        r_sign[k]  <= w_sgn_in[k];
`ifdef SHIFTER_FLAGS_EN
        r_carry[k] <= w_c_in[k];
`endif
      end
    end
  end

  // Last-stage control and consumed low count bits are intentionally dropped.
  always_comb begin
    w_unused = 1'b0;
    for (int k = 0; k < CNT_W; k++) begin
      w_unused = w_unused ^ (^r_cnt[k]) ^ (^r_op[k]) ^ r_sign[k];
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter (WIDTH=16): directed vectors, stream,
// backpressure, mid-flight reset and randomized traffic against an arithmetic reference.
module tb_pipelined_barrel_shifter;

  localparam int W  = 16;
  localparam int CW = 4;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  In = '0;
  logic [CW-1:0] Cnt = '0;
  logic [2:0]    Op = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  Out;
`ifdef SHIFTER_FLAGS_EN
  logic          Zero;
  logic          Carry;
`endif

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .In       (In),
    .Cnt      (Cnt),
    .Op       (Op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Out      (Out)
`ifdef SHIFTER_FLAGS_EN
    ,
    .Zero     (Zero),
    .Carry    (Carry)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic         carry;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int exp_ready = -1;
  bit lat_en = 1'b0;
  bit dir_use = 1'b0;
  logic [W-1:0] dir_out = '0;
  logic dir_carry = 1'b0;
  bit prev_stall = 1'b0;
  logic [W-1:0] prev_out = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a, input int c,
                                             input logic [2:0] op);
    case (op)
      3'd0:    return a << c;
      3'd1:    return a >> c;
      3'd2:    return W'($signed(a) >>> c);
      3'd3:    return (a << c) | (a >> (W - c));
      3'd4:    return (a >> c) | (a << (W - c));
      default: return a;
    endcase
  endfunction

  function automatic logic ref_carry(input logic [W-1:0] a, input int c, input logic [2:0] op);
    if (c == 0 || op > 3'd4) return 1'b0;
    if (op == 3'd0 || op == 3'd3) return a[W-c];
    return a[c-1];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop/compare on output handshake, push model result on input handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_out", Out, prev_out);
      end
      chk("in_ready_eq", in_ready, !out_valid || out_ready);
      if (exp_ready >= 0) chk("in_ready", in_ready, exp_ready != 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h expected no output", Out);
        end else begin
          e = q.pop_front();
          chk("out", Out, e.out);
          if (e.lat && lat_en) chk("latency", cyc + 1 - e.acc, LAT);
`ifdef SHIFTER_FLAGS_EN
          chk("zero", Zero, e.out == '0);
          chk("carry", Carry, e.carry);
`endif
        end
      end
      if (in_valid && in_ready) begin
        e.out   = dir_use ? dir_out : ref_shift(In, int'(Cnt), Op);
        e.carry = dir_use ? dir_carry : ref_carry(In, int'(Cnt), Op);
        e.acc   = cyc + 1;
        e.lat   = lat_en;
        q.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = Out;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [CW-1:0] c, input logic [2:0] op,
                       input bit d, input logic [W-1:0] e, input logic ec);
    int tries = 0;
    In = a; Cnt = c; Op = op; in_valid = 1'b1;
    dir_use = d; dir_out = e; dir_carry = ec;
    @(negedge clk);
    while (!in_ready && tries < 100) begin
      @(posedge clk); #1;
      @(negedge clk);
      tries++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue_rand();
    issue(W'($urandom), CW'($urandom), 3'($urandom_range(0, 7)), 1'b0, '0, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", Out, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed single ops with latency check.
    lat_en = 1'b1;
    issue(16'h00FF, 4'd8, 3'd0, 1'b1, 16'hFF00, 1'b0);  drain();
    issue(16'hFFFF, 4'd15, 3'd1, 1'b1, 16'h0001, 1'b1); drain();
    issue(16'h8000, 4'd3, 3'd2, 1'b1, 16'hF000, 1'b0);  drain();
    issue(16'h8001, 4'd4, 3'd3, 1'b1, 16'h0018, 1'b0);  drain();
    issue(16'h0001, 4'd1, 3'd4, 1'b1, 16'h8000, 1'b1);  drain();

    // Boundaries.
    for (int op = 0; op < 8; op++) issue(16'hA5C3, 4'd0, 3'(op), 1'b1, 16'hA5C3, 1'b0);
    issue(16'hA5C3, 4'd5, 3'b110, 1'b1, 16'hA5C3, 1'b0);
    issue(16'h7FFF, 4'd15, 3'd2, 1'b1, 16'h0000, 1'b1);
    drain();

`ifdef SHIFTER_FLAGS_EN
    issue(16'h0003, 4'd1, 3'd1, 1'b1, 16'h0001, 1'b1);
    issue(16'h8000, 4'd1, 3'd0, 1'b1, 16'h0000, 1'b1);
    issue(16'h1234, 4'd0, 3'd3, 1'b1, 16'h1234, 1'b0);
    drain();
`endif

    // Back-to-back stream of 8.
    exp_ready = 1;
    for (int i = 0; i < 8; i++) issue_rand();
    drain();
    exp_ready = -1;

    // Backpressure: 4 in flight, stall 5 cycles.
    lat_en = 1'b0;
    for (int i = 0; i < 4; i++) issue_rand();
    out_ready = 1'b0;
    exp_ready = 0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    exp_ready = -1;
    drain();

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      In        = W'($urandom);
      Cnt       = CW'($urandom);
      Op        = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      dir_use   = 1'b0;
      @(posedge clk); #1;
    end
    drain();

    // Reset mid-flight while the first result is stalled at the output.
    lat_en = 1'b1;
    for (int i = 0; i < 3; i++) issue_rand();
    out_ready = 1'b0;
    @(posedge clk); #1;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out", Out, 0);
    chk("midrst_in_ready", in_ready, 1);
    q.delete();
    prev_stall = 1'b0;
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_idle", out_valid, 0);
    end
    @(posedge clk); #1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
